// File: rtl/uart_pkg.sv
// Shared UART definitions: register offsets, STAT/CTRL bit indices
// and the TX/RX state encodings.
`ifndef XLEN
`define XLEN 32
`endif
`ifndef ADDR_W
`define ADDR_W 32
`endif
`ifndef IO_BASE_ADDR
`define IO_BASE_ADDR 32'h8000_0000
`endif
`ifndef UART_DIV
`define UART_DIV 16'd16
`endif

package uart_pkg;
  localparam logic [3:0] OFF_DATA = 4'h0;
  localparam logic [3:0] OFF_STAT = 4'h4;
  localparam logic [3:0] OFF_DIV  = 4'h8;
  localparam logic [3:0] OFF_CTRL = 4'hC;

  localparam int ST_TX_BUSY = 0;
  localparam int ST_TX_FULL = 1;
  localparam int ST_RX_NE   = 2;
  localparam int ST_RX_FULL = 3;
  localparam int ST_OVR     = 4;
  localparam int ST_FERR    = 5;
  localparam int ST_PERR    = 6;

  localparam int CT_RX_IE   = 0;
  localparam int CT_TX_IE   = 1;
  localparam int CT_PAR_EN  = 2;
  localparam int CT_PAR_ODD = 3;

  typedef enum logic {TX_IDLE, TX_SHIFT} tx_state_e;
  typedef enum logic [1:0] {
    RX_IDLE, RX_START, RX_DATA, RX_STOP
  } rx_state_e;
endpackage

// File: rtl/uart_fifo_mmio_if.sv
// MMIO request/response bus bundle.
// Master drives the request; slave answers one cycle later.
interface uart_fifo_mmio_if;
  logic               mmio_req;
  logic               mmio_we;
  logic [`ADDR_W-1:0] mmio_addr;
  logic [`XLEN-1:0]   mmio_wdata;
  logic [`XLEN-1:0]   mmio_rdata;
  logic               mmio_ready;

  modport master (
    output mmio_req, mmio_we, mmio_addr, mmio_wdata,
    input  mmio_rdata, mmio_ready
  );
  modport slave (
    input  mmio_req, mmio_we, mmio_addr, mmio_wdata,
    output mmio_rdata, mmio_ready
  );
endinterface

// File: rtl/uart_fifo_mmio_sync_fifo.sv
// Synchronous FIFO, pointers with wrap bit; a push while full
// is accepted when a pop happens in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] ONE = 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wp;
  logic [AW:0]      r_rp;
  logic             w_pop;
  logic             w_push;

  assign empty  = (r_wp == r_rp);
  assign full   = (r_wp[AW] != r_rp[AW]) &&
                  (r_wp[AW-1:0] == r_rp[AW-1:0]);
  assign w_pop  = pop & ~empty;
  assign w_push = push & (~full | w_pop);
  assign dout   = r_mem[r_rp[AW-1:0]];

  // advance read/write pointers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wp <= '0;
      r_rp <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + ONE;
      if (w_pop)  r_rp <= r_rp + ONE;
    end
  end

  // storage array, no reset needed
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wp[AW-1:0]] <= din;
  end
endmodule

// File: rtl/uart_fifo_mmio.sv
// MMIO UART with TX/RX FIFOs, runtime divider, sticky errors, irq.
// Optional parity (CTRL par_en/par_odd, STAT par_err): UART_PARITY_EN.
module uart_fifo_mmio
  import uart_pkg::*;
#(
  parameter logic [`ADDR_W-1:0] BASE_ADDR = `IO_BASE_ADDR + 32'h100,
  parameter int          TX_DEPTH    = 8,
  parameter int          RX_DEPTH    = 8,
  parameter logic [15:0] DEFAULT_DIV = `UART_DIV,
  parameter logic [15:0] MIN_DIV     = 16'd4
) (
  input  logic             clk,
  input  logic             rst_n,
  uart_fifo_mmio_if.slave  bus,
  input  logic             uart_rx,
  output logic             uart_tx,
  output logic             irq
);
  logic        r_pend, r_we, r_hit;
  logic [3:0]  r_off;
  logic [15:0] r_wdata;
  logic [15:0] r_div;
  logic [3:0]  r_ctrl;
  logic        r_ovr, r_ferr, r_perr, r_irq;
  logic        w_accept, w_wr, w_rd;
  logic        w_s_data, w_s_stat, w_s_div, w_s_ctrl;
  logic [6:0]  w_stat;
  logic [`XLEN-1:0] w_rdata;

  logic       w_tx_push, w_tx_pop, w_tx_full, w_tx_empty, w_tx_busy;
  logic [7:0] w_tx_dout;
  logic       w_rx_push, w_rx_pop, w_rx_full, w_rx_empty;
  logic [7:0] w_rx_dout, w_rx_byte;
  logic       w_ovr_set, w_ferr_set, w_perr_set, w_par_bad;
  logic [3:0] w_rx_last;

  tx_state_e   r_tx_state, w_tx_nstate;
  logic [10:0] r_tx_sh, w_tx_nsh;
  logic [3:0]  r_tx_bits, w_tx_nbits;
  logic [15:0] r_tx_cnt, w_tx_ncnt, r_tx_div, w_tx_ndiv;

  rx_state_e   r_rx_state, w_rx_nstate;
  logic        r_rx_s1, r_rx_s2, r_rx_prev;
  logic [8:0]  r_rx_sh, w_rx_nsh;
  logic [3:0]  r_rx_bits, w_rx_nbits;
  logic [15:0] r_rx_cnt, w_rx_ncnt, r_rx_div, w_rx_ndiv;

  wire w_unused_ok = ^{bus.mmio_wdata[`XLEN-1:16], r_rx_sh[0]};

  assign w_accept = bus.mmio_req & ~r_pend;
  assign w_wr     = r_pend & r_we & r_hit;
  assign w_rd     = r_pend & ~r_we & r_hit;
  assign w_s_data = (r_off == OFF_DATA);
  assign w_s_stat = (r_off == OFF_STAT);
  assign w_s_div  = (r_off == OFF_DIV);
  assign w_s_ctrl = (r_off == OFF_CTRL);

  assign w_tx_push = w_wr & w_s_data;
  assign w_rx_pop  = w_rd & w_s_data;
  assign w_tx_busy = ~w_tx_empty | (r_tx_state == TX_SHIFT);
  assign w_stat    = {r_perr, r_ferr, r_ovr, w_rx_full,
                      ~w_rx_empty, w_tx_full, w_tx_busy};

  assign bus.mmio_ready = r_pend;
  assign bus.mmio_rdata = w_rdata;
  assign uart_tx        = r_tx_sh[0];
  assign irq            = r_irq;

`ifdef UART_PARITY_EN
  assign w_rx_last = r_ctrl[CT_PAR_EN] ? 4'd8 : 4'd7;
  assign w_rx_byte = r_ctrl[CT_PAR_EN] ? r_rx_sh[7:0] : r_rx_sh[8:1];
  assign w_par_bad = r_ctrl[CT_PAR_EN] &
    (r_rx_sh[8] != (^r_rx_sh[7:0] ^ r_ctrl[CT_PAR_ODD]));
`else
  assign w_rx_last = 4'd7;
  assign w_rx_byte = r_rx_sh[8:1];
  assign w_par_bad = 1'b0;
`endif

  sync_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk(clk), .rst_n(rst_n), .push(w_tx_push), .pop(w_tx_pop),
    .din(r_wdata[7:0]), .dout(w_tx_dout),
    .full(w_tx_full), .empty(w_tx_empty)
  );

  sync_fifo #(.WIDTH(8), .DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk(clk), .rst_n(rst_n), .push(w_rx_push), .pop(w_rx_pop),
    .din(w_rx_byte), .dout(w_rx_dout),
    .full(w_rx_full), .empty(w_rx_empty)
  );

  // read data mux, zero outside the response cycle
  always_comb begin
    w_rdata = '0;
    if (w_rd) begin
      unique case (1'b1)
        w_s_data: if (!w_rx_empty) w_rdata[8:0] = {1'b1, w_rx_dout};
        w_s_stat: w_rdata[6:0]  = w_stat;
        w_s_div:  w_rdata[15:0] = r_div;
        w_s_ctrl: w_rdata[3:0]  = r_ctrl;
        default:  w_rdata = '0;
      endcase
    end
  end

  // request latch, register writes, sticky flags, irq
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend  <= 1'b0;
      r_we    <= 1'b0;
      r_hit   <= 1'b0;
      r_off   <= '0;
      r_wdata <= '0;
      r_div   <= DEFAULT_DIV;
      r_ctrl  <= '0;
      r_ovr   <= 1'b0;
      r_ferr  <= 1'b0;
      r_perr  <= 1'b0;
      r_irq   <= 1'b0;
    end else begin
      r_pend <= w_accept;
      if (w_accept) begin
        r_we    <= bus.mmio_we;
        r_off   <= bus.mmio_addr[3:0];
        r_wdata <= bus.mmio_wdata[15:0];
        r_hit   <= bus.mmio_addr[`ADDR_W-1:4] ==
                   BASE_ADDR[`ADDR_W-1:4];
      end
      if (w_wr && w_s_div)
        r_div <= (r_wdata < MIN_DIV) ? MIN_DIV : r_wdata;
`ifdef UART_PARITY_EN
      if (w_wr && w_s_ctrl) r_ctrl <= r_wdata[3:0];
`else
      if (w_wr && w_s_ctrl) r_ctrl <= {2'b00, r_wdata[1:0]};
`endif
      r_ovr  <= (r_ovr & ~(w_wr & w_s_stat & r_wdata[ST_OVR]))
                | w_ovr_set;
      r_ferr <= (r_ferr & ~(w_wr & w_s_stat & r_wdata[ST_FERR]))
                | w_ferr_set;
      r_perr <= (r_perr & ~(w_wr & w_s_stat & r_wdata[ST_PERR]))
                | w_perr_set;
      r_irq  <= (r_ctrl[CT_RX_IE] & ~w_rx_empty) |
                (r_ctrl[CT_TX_IE] & ~w_tx_busy);
    end
  end

  // TX state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tx_state <= TX_IDLE;
      r_tx_sh    <= '1;
      r_tx_bits  <= '0;
      r_tx_cnt   <= '0;
      r_tx_div   <= DEFAULT_DIV;
    end else begin
      r_tx_state <= w_tx_nstate;
      r_tx_sh    <= w_tx_nsh;
      r_tx_bits  <= w_tx_nbits;
      r_tx_cnt   <= w_tx_ncnt;
      r_tx_div   <= w_tx_ndiv;
    end
  end

  // TX next state; stop bit's last clock is spent in IDLE so a
  // queued byte follows without an extra idle bit
  always_comb begin
    w_tx_nstate = r_tx_state;
    w_tx_nsh    = r_tx_sh;
    w_tx_nbits  = r_tx_bits;
    w_tx_ncnt   = r_tx_cnt;
    w_tx_ndiv   = r_tx_div;
    w_tx_pop    = 1'b0;
    unique case (r_tx_state)
      TX_IDLE: if (!w_tx_empty) begin
        w_tx_pop    = 1'b1;
        w_tx_nstate = TX_SHIFT;
        w_tx_ndiv   = r_div;
        w_tx_ncnt   = r_div - 16'd1;
        w_tx_nsh    = {2'b11, w_tx_dout, 1'b0};
        w_tx_nbits  = 4'd10;
`ifdef UART_PARITY_EN
        if (r_ctrl[CT_PAR_EN]) begin
          w_tx_nsh   = {1'b1, ^w_tx_dout ^ r_ctrl[CT_PAR_ODD],
                        w_tx_dout, 1'b0};
          w_tx_nbits = 4'd11;
        end
`endif
      end
      TX_SHIFT: begin
        if (r_tx_bits == 4'd1 && r_tx_cnt == 16'd1) begin
          w_tx_nstate = TX_IDLE;
          w_tx_nsh    = '1;
        end else if (r_tx_cnt == 16'd0) begin
          w_tx_nsh   = {1'b1, r_tx_sh[10:1]};
          w_tx_nbits = r_tx_bits - 4'd1;
          w_tx_ncnt  = r_tx_div - 16'd1;
        end else begin
          w_tx_ncnt = r_tx_cnt - 16'd1;
        end
      end
      default: w_tx_nstate = TX_IDLE;
    endcase
  end

  // RX synchroniser and state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_s1    <= 1'b1;
      r_rx_s2    <= 1'b1;
      r_rx_prev  <= 1'b1;
      r_rx_state <= RX_IDLE;
      r_rx_sh    <= '0;
      r_rx_bits  <= '0;
      r_rx_cnt   <= '0;
      r_rx_div   <= DEFAULT_DIV;
    end else begin
      r_rx_s1    <= uart_rx;
      r_rx_s2    <= r_rx_s1;
      r_rx_prev  <= r_rx_s2;
      r_rx_state <= w_rx_nstate;
      r_rx_sh    <= w_rx_nsh;
      r_rx_bits  <= w_rx_nbits;
      r_rx_cnt   <= w_rx_ncnt;
      r_rx_div   <= w_rx_ndiv;
    end
  end

  // RX next state, mid-bit sampling and frame verdict
  always_comb begin
    w_rx_nstate = r_rx_state;
    w_rx_nsh    = r_rx_sh;
    w_rx_nbits  = r_rx_bits;
    w_rx_ncnt   = r_rx_cnt;
    w_rx_ndiv   = r_rx_div;
    w_rx_push   = 1'b0;
    w_ovr_set   = 1'b0;
    w_ferr_set  = 1'b0;
    w_perr_set  = 1'b0;
    unique case (r_rx_state)
      RX_IDLE: if (r_rx_prev && !r_rx_s2) begin
        w_rx_nstate = RX_START;
        w_rx_ndiv   = r_div;
        w_rx_ncnt   = {1'b0, r_div[15:1]} - 16'd1;
      end
      RX_START: begin
        if (r_rx_cnt != 16'd0) begin
          w_rx_ncnt = r_rx_cnt - 16'd1;
        end else if (r_rx_s2) begin
          w_rx_nstate = RX_IDLE;
        end else begin
          w_rx_nstate = RX_DATA;
          w_rx_ncnt   = r_rx_div - 16'd1;
          w_rx_nbits  = '0;
        end
      end
      RX_DATA: begin
        if (r_rx_cnt != 16'd0) begin
          w_rx_ncnt = r_rx_cnt - 16'd1;
        end else begin
          w_rx_nsh   = {r_rx_s2, r_rx_sh[8:1]};
          w_rx_nbits = r_rx_bits + 4'd1;
          w_rx_ncnt  = r_rx_div - 16'd1;
          if (r_rx_bits == w_rx_last) w_rx_nstate = RX_STOP;
        end
      end
      RX_STOP: begin
        if (r_rx_cnt != 16'd0) begin
          w_rx_ncnt = r_rx_cnt - 16'd1;
        end else begin
          w_rx_nstate = RX_IDLE;
          if (!r_rx_s2)                  w_ferr_set = 1'b1;
          else if (w_par_bad)            w_perr_set = 1'b1;
          else if (w_rx_full && !w_rx_pop) w_ovr_set = 1'b1;
          else                           w_rx_push  = 1'b1;
        end
      end
      default: w_rx_nstate = RX_IDLE;
    endcase
  end
endmodule

// File: tb/tb_uart_fifo_mmio.sv
// Randomised bench for uart_fifo_mmio against a queue-based model
// of the register map, FIFOs and 8N1 framing.
module tb_uart_fifo_mmio;
  import uart_pkg::*;

  localparam logic [31:0] BASE = `IO_BASE_ADDR + 32'h100;
  localparam int TXD = 8;
  localparam int RXD = 8;
  localparam int DEF_DIV = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic uart_rx = 1'b1;
  logic uart_tx, irq;
  int   n_tests = 0;
  int   n_fail = 0;
  logic cap = 1'b0;
  bit   txlog[$];

  uart_fifo_mmio_if bus();

  uart_fifo_mmio #(.TX_DEPTH(TXD), .RX_DEPTH(RXD)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.slave),
    .uart_rx(uart_rx), .uart_tx(uart_tx), .irq(irq)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (cap) txlog.push_back(uart_tx);

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic acc(input logic we, input logic [31:0] a,
                     input logic [31:0] wd, output logic [31:0] rd);
    int n;
    bus.mmio_req = 1'b1;
    bus.mmio_we = we;
    bus.mmio_addr = a;
    bus.mmio_wdata = wd;
    n = 0;
    do begin
      @(posedge clk);
      @(negedge clk);
      n++;
    end while (!bus.mmio_ready && n < 4);
    rd = bus.mmio_rdata;
    bus.mmio_req = 1'b0;
    if (!bus.mmio_ready) check("mmio_timeout", 0, 1);
  endtask

  task automatic wr(input logic [3:0] off, input logic [31:0] d);
    logic [31:0] x;
    acc(1'b1, BASE + {28'h0, off}, d, x);
  endtask

  task automatic rd(input logic [3:0] off, output logic [31:0] d);
    acc(1'b0, BASE + {28'h0, off}, 32'h0, d);
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop,
                         input int div);
    logic [9:0] fr;
    fr = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      uart_rx = fr[i];
      repeat (div) @(negedge clk);
    end
    uart_rx = 1'b1;
    repeat (div + 4) @(negedge clk);
  endtask

  // find falling edges in the captured line; every bit of every
  // frame must hold for exactly div clocks, frames back to back
  task automatic check_tx(input string tag, input logic [7:0] exp[$],
                          input int div);
    int i, k, prev, bad, extra, p;
    logic [9:0] fr;
    i = 1; k = 0; prev = -1; extra = 0;
    while (i < txlog.size() && k < exp.size()) begin
      if (txlog[i-1] && !txlog[i]) begin
        fr = {1'b1, exp[k], 1'b0};
        bad = 0;
        for (int b = 0; b < 10; b++)
          for (int c = 0; c < div; c++) begin
            p = i + b * div + c;
            if (p >= txlog.size()) bad++;
            else if (txlog[p] != fr[b]) bad++;
          end
        check($sformatf("%s_frame%0d_badclk", tag, k), bad, 0);
        if (k > 0)
          check($sformatf("%s_gap%0d", tag, k), i - prev, 10 * div);
        prev = i;
        k++;
        i += 10 * div;
      end else begin
        i++;
      end
    end
    for (int j = i; j < txlog.size(); j++)
      if (j > 0 && txlog[j-1] && !txlog[j]) extra++;
    check({tag, "_nframes"}, k, exp.size());
    check({tag, "_extra"}, extra, 0);
  endtask

  function automatic logic [31:0] stat_exp(int qn, bit ovr, bit ferr);
    stat_exp = 0;
    stat_exp[ST_RX_NE]   = (qn != 0);
    stat_exp[ST_RX_FULL] = (qn == RXD);
    stat_exp[ST_OVR]     = ovr;
    stat_exp[ST_FERR]    = ferr;
  endfunction

  initial begin
    logic [31:0] d;
    logic [7:0]  q[$];
    logic [7:0]  txq[$];
    bit          m_ovr, m_ferr;
    int          div, n;
    logic [7:0]  b;

    bus.mmio_req = 1'b0;
    bus.mmio_we = 1'b0;
    bus.mmio_addr = '0;
    bus.mmio_wdata = '0;
    repeat (3) @(negedge clk);
    check("rst_tx", uart_tx, 1);
    check("rst_irq", irq, 0);
    check("rst_ready", bus.mmio_ready, 0);
    check("rst_rdata", bus.mmio_rdata, 0);
    rst_n = 1'b1;
    @(negedge clk);
    rd(OFF_STAT, d); check("rst_stat", d, 0);
    rd(OFF_DIV, d);  check("rst_div", d, DEF_DIV);
    rd(OFF_CTRL, d); check("rst_ctrl", d, 0);
    rd(OFF_DATA, d); check("rst_data", d, 0);

    wr(OFF_DIV, 32'h1); rd(OFF_DIV, d); check("div_clamp", d, 4);
    wr(OFF_DIV, 32'h1_0007); rd(OFF_DIV, d); check("div_16b", d, 7);
    acc(1'b1, BASE + 32'h1C, 32'h3, d);
    rd(OFF_CTRL, d); check("alias_wr_ignored", d, 0);
    acc(1'b0, BASE + 32'h18, 0, d); check("unmapped_out", d, 0);
    acc(1'b0, BASE + 32'h2, 0, d); check("unmapped_in", d, 0);

    wr(OFF_DIV, 4);
    txlog.delete(); cap = 1'b1;
    wr(OFF_DATA, 32'h55); wr(OFF_DATA, 32'hA3);
    repeat (100) @(negedge clk);
    cap = 1'b0;
    txq = '{8'h55, 8'hA3};
    check_tx("tx_b2b", txq, 4);

    txlog.delete(); cap = 1'b1; txq.delete();
    for (int i = 0; i < TXD + 2; i++) begin
      b = 8'($urandom);
      if (i < TXD + 1) txq.push_back(b);
      wr(OFF_DATA, {24'h0, b});
    end
    rd(OFF_STAT, d); check("tx_full_stat", d, 32'h3);
    repeat ((TXD + 1) * 40 + 20) @(negedge clk);
    cap = 1'b0;
    check_tx("tx_drop", txq, 4);
    rd(OFF_STAT, d); check("tx_drained", d, 0);

    for (int r = 0; r < 3; r++) begin
      div = $urandom_range(7, 4);
      n = $urandom_range(TXD + 1, 1);
      wr(OFF_DIV, div);
      txlog.delete(); cap = 1'b1; txq.delete();
      for (int i = 0; i < n; i++) begin
        b = 8'($urandom);
        txq.push_back(b);
        wr(OFF_DATA, {24'h0, b});
      end
      repeat (n * 10 * div + 20) @(negedge clk);
      cap = 1'b0;
      check_tx($sformatf("tx_rand%0d", r), txq, div);
    end

    wr(OFF_DIV, 4);
    send_rx(8'h3C, 1'b1, 4);
    rd(OFF_STAT, d); check("rx_ne", d, 32'h4);
    rd(OFF_DATA, d); check("rx_data", d, 32'h13C);
    rd(OFF_DATA, d); check("rx_empty_rd", d, 0);

    q.delete(); m_ovr = 0; m_ferr = 0;
    for (int i = 0; i < RXD + 1; i++) begin
      b = 8'($urandom);
      if (q.size() < RXD) q.push_back(b); else m_ovr = 1;
      send_rx(b, 1'b1, 4);
    end
    rd(OFF_STAT, d); check("ovr_stat", d, stat_exp(q.size(), m_ovr, 0));
    for (int i = 0; i < RXD + 1; i++) begin
      rd(OFF_DATA, d);
      check($sformatf("ovr_rd%0d", i), d,
            q.size() ? {23'h0, 1'b1, q.pop_front()} : 32'h0);
    end
    wr(OFF_STAT, 32'h10);
    rd(OFF_STAT, d); check("ovr_w1c", d, 0);

    send_rx(8'h5A, 1'b0, 4);
    rd(OFF_STAT, d); check("ferr_stat", d, 32'h20);
    wr(OFF_STAT, 32'h20);
    uart_rx = 1'b0; @(negedge clk); uart_rx = 1'b1;
    repeat (30) @(negedge clk);
    rd(OFF_STAT, d); check("glitch_stat", d, 0);

    q.delete(); m_ovr = 0; m_ferr = 0;
    for (int i = 0; i < 24; i++) begin
      if ($urandom_range(2, 0) != 0) begin
        div = $urandom_range(6, 4);
        wr(OFF_DIV, div);
        b = 8'($urandom);
        if ($urandom_range(5, 0) == 0) begin
          m_ferr = 1;
          send_rx(b, 1'b0, div);
        end else begin
          if (q.size() < RXD) q.push_back(b); else m_ovr = 1;
          send_rx(b, 1'b1, div);
        end
      end else begin
        rd(OFF_DATA, d);
        check($sformatf("rand_rd%0d", i), d,
              q.size() ? {23'h0, 1'b1, q.pop_front()} : 32'h0);
      end
    end
    rd(OFF_STAT, d);
    check("rand_stat", d, stat_exp(q.size(), m_ovr, m_ferr));
    while (q.size() != 0) begin
      rd(OFF_DATA, d);
      check("rand_drain", d, {23'h0, 1'b1, q.pop_front()});
    end
    wr(OFF_STAT, 32'h30);

    wr(OFF_DIV, 4);
    wr(OFF_CTRL, 32'h1);
    @(negedge clk); check("irq_idle", irq, 0);
    send_rx(8'h7E, 1'b1, 4);
    check("irq_rx", irq, 1);
    rd(OFF_DATA, d); check("irq_data", d, 32'h17E);
    @(negedge clk); check("irq_hold", irq, 1);
    @(negedge clk); check("irq_fall", irq, 0);
    wr(OFF_CTRL, 32'h2);
    repeat (2) @(negedge clk); check("irq_tx_idle", irq, 1);
    wr(OFF_CTRL, 32'h0);
    repeat (2) @(negedge clk); check("irq_off", irq, 0);

    wr(OFF_DIV, 8);
    wr(OFF_DATA, 32'h00); wr(OFF_DATA, 32'hF0);
    repeat (30) @(negedge clk);
    check("mid_frame_low", uart_tx, 0);
    rst_n = 1'b0;
    #1 check("rst_mid_tx", uart_tx, 1);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    txlog.delete(); cap = 1'b1;
    rd(OFF_STAT, d); check("rst_mid_stat", d, 0);
    rd(OFF_DIV, d);  check("rst_mid_div", d, DEF_DIV);
    repeat (60) @(negedge clk);
    cap = 1'b0;
    txq.delete();
    check_tx("rst_quiet", txq, DEF_DIV);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/uart_fifo_mmio.md
Name: uart_fifo_mmio

Overview:
- Next-generation MMIO UART for the SoC IO region; successor to the single-byte TX-only UART path.
- Adds a parametrised-depth TX FIFO, a full RX path with its own FIFO, a runtime-programmable baud divider, sticky error flags and a level interrupt.
- Sits on the standard mmio request/response bus beside the LED/segment peripheral.

Parameters:
- BASE_ADDR, `IO_BASE_ADDR + 32'h100: base of the 16-byte register window.
- TX_DEPTH, 8: TX FIFO entries; power of 2, minimum 2.
- RX_DEPTH, 8: RX FIFO entries; power of 2, minimum 2.
- DEFAULT_DIV, `UART_DIV: reset value of DIV (clocks per bit).
- MIN_DIV, 4: smallest legal divider; writes below it are clamped up to it.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- mmio_req  in  1  request strobe
- mmio_we  in  1  1 = write
- mmio_addr  in  `ADDR_W  byte address
- mmio_wdata  in  `XLEN  write data
- mmio_rdata  out  `XLEN  read data, valid while mmio_ready is high
- mmio_ready  out  1  one-cycle response
- uart_rx  in  1  serial input, asynchronous, idle high
- uart_tx  out  1  serial output, idle high
- irq  out  1  level interrupt

Behaviour:
- Reset (asynchronous on rst_n low, including mid-frame): both FIFOs empty, DIV=DEFAULT_DIV, CTRL=0, sticky flags 0, uart_tx=1, irq=0, mmio_ready=0, mmio_rdata=0.
- Handshake:
  - Request is accepted when mmio_req && !pending; address, we and wdata are latched.
  - mmio_ready pulses exactly one cycle later, so latency is 1 and back-to-back throughput is one request per 2 cycles.
  - A req held high during the pending cycle is ignored.
  - Every access completes, including unmapped ones.
- Register map (offset, access, function):
  - DATA 0x0, write: push wdata[7:0] to TX FIFO; dropped silently when full.
  - DATA 0x0, read: pop RX FIFO; rdata = {23'b0, valid, byte}. Returns 0 and does not pop when empty.
  - STAT 0x4, read: bit0 tx_busy (FIFO non-empty or shifter active), bit1 tx_full, bit2 rx_nonempty, bit3 rx_full, bit4 overrun, bit5 frame_err.
  - STAT 0x4, write: writing 1 to bit4 or bit5 clears that flag (W1C).
  - DIV 0x8, read/write: [15:0]. Written value < MIN_DIV is stored as MIN_DIV. A new value takes effect at the next frame start on each path; an in-flight frame finishes at the old rate.
  - CTRL 0xC, read/write: bit0 rx_ie, bit1 tx_ie.
  - Unmapped addresses: read 0, writes ignored.
- TX state machine IDLE -> SHIFT -> IDLE:
  - IDLE: if the FIFO is non-empty, pop and load {1, byte, 0}, set 10 bits left, counter=DIV-1.
  - SHIFT: shift LSB first, each bit held DIV clocks. After the stop bit, return to IDLE. A queued byte starts on the cycle after IDLE is re-entered, with no extra idle bits.
- RX path:
  - uart_rx passes through a 2-flop synchroniser.
  - State machine IDLE -> START -> DATA -> STOP.
  - IDLE: a falling edge enters START and waits DIV/2 clocks. If the line is high at the mid-point, treat it as a glitch and return to IDLE.
  - DATA: sample 8 bits every DIV clocks, LSB first.
  - STOP: sample the stop bit.
    - Stop=0: set frame_err, discard the byte.
    - Stop=1 and FIFO full: set overrun, discard the byte.
    - Stop=1 otherwise: push the byte.
  - Return to IDLE in every case.
- Simultaneous events:
  - RX push and MMIO pop in the same cycle are both honoured; occupancy is unchanged.
  - TX push and shifter pop in the same cycle are both honoured. A push to a full FIFO in the cycle the shifter pops is accepted.
  - A W1C clear in the same cycle as a new error set leaves the flag set (set wins).
- irq = (rx_ie & rx_nonempty) | (tx_ie & !tx_busy), registered, 1 cycle after the cause.
- FIFO pointers carry one extra wrap bit: full = MSBs differ and lower bits equal.

Optional Feature:
- Macro UART_PARITY_EN.
- Defined:
  - CTRL bit2 par_en and bit3 par_odd are added.
  - When par_en=1 the frame is 11 bits: parity is inserted after the data bits and checked on RX.
  - A parity mismatch sets sticky STAT bit6 par_err (W1C) and the byte is discarded.
- Undefined: CTRL bits 2-3 and STAT bit6 read 0; frames are always 8N1.

Decomposition:
- Shared package uart_pkg holds:
  - register offsets;
  - STAT and CTRL bit indices;
  - the TX and RX state enums.
- Sub-module sync_fifo (parameters WIDTH, DEPTH; ports push, pop, din, dout, full, empty) is instantiated twice.
- TX and RX state machines stay inline.

Test Plan:
- Write DIV=4, write DATA 0x55, 0xA3 back-to-back -> uart_tx carries start, 0x55 LSB-first, stop, then 0xA3 with no gap; each bit is 4 clocks; 80 clocks total.
- With DIV=4, write TX_DEPTH+2 bytes while line busy -> first byte loaded to the shifter immediately, next TX_DEPTH queued, last byte dropped; STAT bit1 set while full.
- Drive uart_rx with frame 0x3C at DIV=4 -> STAT bit2=1. Read DATA returns 0x13C; a second read returns 0x000.
- Send RX_DEPTH+1 frames without reading -> STAT bit4=1 and FIFO holds the first RX_DEPTH bytes. Write STAT 0x10 -> bit4=0.
- RX frame with stop bit 0 -> STAT bit5=1, FIFO empty. A 1-clock low glitch on uart_rx -> no byte, no error.
- CTRL=0x1, receive 0x7E -> irq rises, then falls 1 cycle after the pop. Assert rst_n low mid-TX frame -> uart_tx=1 immediately and the FIFO is empty after release.
